// File: rtl/xmm_fixed_muldiv_writer_pkg.sv
// Shared constants, state encoding and helpers for the Xmm fixed-point mul/div writer.
// Values are signed q15.48: 1.0 == 1 << 48.
package xmm_pkg;

    localparam int XMM_WIDTH     = 64;
    localparam int XMM_FRAC_BITS = 48;
    localparam int ACC_WIDTH     = 2 * XMM_WIDTH;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [XMM_WIDTH-1:0] Q_ONE = 64'h0001_0000_0000_0000;
    localparam logic [XMM_WIDTH-1:0] Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [XMM_WIDTH-1:0] Q_MIN = 64'h8000_0000_0000_0000;

    localparam logic [6:0] MUL_ITERS = 7'd64;
    localparam logic [6:0] DIV_ITERS = 7'd112;

    // The magnitude of the most negative value (2^63) still fits in unsigned 64 bits.
    function automatic logic [XMM_WIDTH-1:0] abs_mag(input logic [XMM_WIDTH-1:0] v);
        return v[XMM_WIDTH-1] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/xmm_fixed_muldiv_writer_if.sv
// Request and Xmm write-port bundle between a requester and the mul/div writer.
// start is honoured only on a posedge where busy==0; the op and operands are sampled on
// that edge alone. done, should_write, write_addr and write_data are registered and valid
// together for exactly one cycle (the write-back cycle).
interface xmm_fixed_muldiv_writer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             op;
    logic [4:0]       dest_addr;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             should_write;
    logic [4:0]       write_addr;
    logic [WIDTH-1:0] write_data;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, op, dest_addr, operand_a, operand_b,
        input  busy, done, should_write, write_addr, write_data, overflow, div_by_zero
    );

    modport slave (
        input  start, op, dest_addr, operand_a, operand_b,
        output busy, done, should_write, write_addr, write_data, overflow, div_by_zero
    );
endinterface

// File: rtl/xmm_fixed_muldiv_writer_saturate.sv
// Applies a sign to an unsigned magnitude and clamps to the signed 64-bit range.
// Negative magnitudes up to 2^63 are representable; positive ones stop at 2^63-1.
module xmm_saturate
    import xmm_pkg::*;
(
    input  logic                 sign,
    input  logic [ACC_WIDTH-1:0] mag,
    output logic [XMM_WIDTH-1:0] result,
    output logic                 overflow
);
    logic pos_over;
    logic neg_over;

    assign pos_over = mag > {{XMM_WIDTH{1'b0}}, Q_MAX};
    assign neg_over = mag > {{XMM_WIDTH{1'b0}}, Q_MIN};

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (sign) begin
            overflow = neg_over;
            result   = neg_over ? Q_MIN : (~mag[XMM_WIDTH-1:0] + 64'd1);
        end else begin
            overflow = pos_over;
            result   = pos_over ? Q_MAX : mag[XMM_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/xmm_fixed_muldiv_writer.sv
// Iterative signed q15.48 multiply/divide unit that issues a single registered write
// into the Xmm register file once the result is ready.
module xmm_fixed_muldiv_writer
    import xmm_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    xmm_fixed_muldiv_writer_if.slave      bus,
    output state_t                        dbg_state
);
    state_t state, state_nxt;

    logic                 op_q;
    logic                 sign_q;
    logic                 a_neg_q;
    logic                 b_zero_q;
    logic [4:0]           dest_q;
    logic [XMM_WIDTH-1:0] a_mag;
    logic [XMM_WIDTH-1:0] b_mag;
    logic [ACC_WIDTH-1:0] acc;
    logic [XMM_WIDTH-1:0] rem;
    logic [6:0]           iter;

    logic                 done_q;
    logic                 should_write_q;
    logic [4:0]           write_addr_q;
    logic [XMM_WIDTH-1:0] write_data_q;
    logic                 overflow_q;
    logic                 div_by_zero_q;

    logic                 accept;
    logic                 last_iter;
    logic                 in_div_zero;

    assign accept      = (state == ST_IDLE) && bus.start;
    assign last_iter   = iter == ((op_q == OP_DIV) ? (DIV_ITERS - 7'd1) : (MUL_ITERS - 7'd1));
    assign in_div_zero = bus.op == OP_DIV && bus.operand_b == '0;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = in_div_zero ? ST_FIX : ST_CALC;
            ST_CALC: if (last_iter) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Multiply step: add |a| into the upper half when the current multiplier bit is set,
    // then shift the whole product right; the multiplier drains out of the low half.
    logic [XMM_WIDTH:0]   mul_sum;
    logic [ACC_WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[ACC_WIDTH-1:XMM_WIDTH]} + (acc[0] ? {1'b0, a_mag} : 65'd0);
    assign mul_next = {mul_sum, acc[XMM_WIDTH-1:1]};

    // Restoring divide step over the 112-bit dividend held in acc[111:0].
    logic [XMM_WIDTH:0]   div_shift;
    logic [XMM_WIDTH:0]   div_diff;
    logic                 div_fits;
    logic [XMM_WIDTH-1:0] div_rem_next;
    logic [ACC_WIDTH-1:0] div_next;

    assign div_shift    = {rem, acc[111]};
    assign div_diff     = div_shift - {1'b0, b_mag};
    assign div_fits     = div_shift >= {1'b0, b_mag};
    assign div_rem_next = div_fits ? div_diff[XMM_WIDTH-1:0] : div_shift[XMM_WIDTH-1:0];
    assign div_next     = {16'd0, acc[110:0], div_fits};

    logic [ACC_WIDTH-1:0] fix_mag;
    logic [XMM_WIDTH-1:0] sat_result;
    logic                 sat_overflow;
    logic [XMM_WIDTH-1:0] fix_result;
    logic                 fix_overflow;
    logic                 fix_div_zero;

    assign fix_mag = (op_q == OP_MUL) ? (acc >> XMM_FRAC_BITS) : acc;

    xmm_saturate u_saturate (
        .sign     (sign_q),
        .mag      (fix_mag),
        .result   (sat_result),
        .overflow (sat_overflow)
    );

    always_comb begin
        fix_result   = sat_result;
        fix_overflow = sat_overflow;
        fix_div_zero = 1'b0;
        if (op_q == OP_DIV && b_zero_q) begin
            fix_result   = a_neg_q ? Q_MIN : Q_MAX;
            fix_overflow = 1'b0;
            fix_div_zero = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= OP_MUL;
            sign_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            dest_q   <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            rem      <= '0;
            iter     <= '0;
        end else if (accept) begin
            op_q     <= bus.op;
            sign_q   <= bus.operand_a[XMM_WIDTH-1] ^ bus.operand_b[XMM_WIDTH-1];
            a_neg_q  <= bus.operand_a[XMM_WIDTH-1];
            b_zero_q <= bus.operand_b == '0;
            dest_q   <= bus.dest_addr;
            a_mag    <= abs_mag(bus.operand_a);
            b_mag    <= abs_mag(bus.operand_b);
            acc      <= (bus.op == OP_MUL)
                        ? {{XMM_WIDTH{1'b0}}, abs_mag(bus.operand_b)}
                        : {16'd0, abs_mag(bus.operand_a), {XMM_FRAC_BITS{1'b0}}};
            rem      <= '0;
            iter     <= '0;
        end else if (state == ST_CALC) begin
            acc  <= (op_q == OP_MUL) ? mul_next : div_next;
            if (op_q == OP_DIV) rem <= div_rem_next;
            iter <= iter + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q         <= 1'b0;
            should_write_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            overflow_q     <= 1'b0;
            div_by_zero_q  <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            should_write_q <= 1'b0;
            if (accept) begin
                overflow_q    <= 1'b0;
                div_by_zero_q <= 1'b0;
            end
            if (state == ST_FIX) begin
                done_q         <= 1'b1;
                should_write_q <= dest_q != 5'd0;
                write_addr_q   <= dest_q;
                write_data_q   <= fix_result;
                overflow_q     <= fix_overflow;
                div_by_zero_q  <= fix_div_zero;
            end
        end
    end

    assign bus.busy         = state != ST_IDLE;
    assign bus.done         = done_q;
    assign bus.should_write = should_write_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;
    assign bus.overflow     = overflow_q;
    assign bus.div_by_zero  = div_by_zero_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_xmm_fixed_muldiv_writer.sv
// Directed bench for the Xmm mul/div writer: hand-computed q15.48 results, write-back
// cycle timing, saturation, divide-by-zero, dest 0, busy-time starts and mid-op reset.
module tb_xmm_fixed_muldiv_writer;
    import xmm_pkg::*;

    logic   clk;
    logic   reset;
    state_t dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    xmm_fixed_muldiv_writer_if #(.WIDTH(64)) bus ();

    xmm_fixed_muldiv_writer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.op        = 1'($urandom_range(0, 1));
        bus.dest_addr = 5'($urandom_range(0, 31));
        bus.operand_a = {$urandom, $urandom};
        bus.operand_b = {$urandom, $urandom};
    endtask

    // Issues one op and follows it to write-back; exp_cyc counts the accept edge as cycle 0.
    task automatic run_op(input string name, input logic opv, input logic [4:0] dst,
                          input logic [63:0] av, input logic [63:0] bv, input int exp_cyc,
                          input logic [63:0] exp_data, input logic exp_ovf,
                          input logic exp_dz, input bit inject);
        int  n;
        int  early_sw;
        bit  seen;
        @(negedge clk);
        check({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
        bus.start     = 1'b1;
        bus.op        = opv;
        bus.dest_addr = dst;
        bus.operand_a = av;
        bus.operand_b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_inputs();
        check({name, "_busy_c1"}, 64'(bus.busy), 64'd1);
        n = 0;
        early_sw = 0;
        seen = 0;
        while (!seen && n < 200) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                if (bus.should_write) early_sw++;
                if (inject && n == 9) begin
                    bus.start = 1'b1;
                    scramble_inputs();
                end
                if (inject && n == 10) bus.start = 1'b0;
                @(posedge clk); #1;
                n++;
            end
        end
        bus.start = 1'b0;
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_early_sw"}, 64'(early_sw), 64'd0);
        if (seen) begin
            check({name, "_wb_cycle"}, 64'(n + 1), 64'(exp_cyc));
            check({name, "_data"}, bus.write_data, exp_data);
            check({name, "_addr"}, 64'(bus.write_addr), 64'(dst));
            check({name, "_sw"}, 64'(bus.should_write), 64'(dst != 5'd0));
            check({name, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
            check({name, "_dz"}, 64'(bus.div_by_zero), 64'(exp_dz));
            check({name, "_busy_wb"}, 64'(bus.busy), 64'd1);
            @(posedge clk); #1;
            check({name, "_done_drop"}, 64'(bus.done), 64'd0);
            check({name, "_sw_drop"}, 64'(bus.should_write), 64'd0);
            check({name, "_busy_drop"}, 64'(bus.busy), 64'd0);
            check({name, "_data_held"}, bus.write_data, exp_data);
            check({name, "_ovf_held"}, 64'(bus.overflow), 64'(exp_ovf));
        end
    endtask

    task automatic reset_mid_op();
        int pulses;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = OP_MUL;
        bus.dest_addr = 5'd9;
        bus.operand_a = 64'h0003_0000_0000_0000;
        bus.operand_b = 64'h0003_0000_0000_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 30; i++) begin
            @(posedge clk); #1;
        end
        check("rst_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_sw", 64'(bus.should_write), 64'd0);
        check("rst_addr", 64'(bus.write_addr), 64'd0);
        check("rst_data", bus.write_data, 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        check("rst_dz", 64'(bus.div_by_zero), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.should_write) pulses++;
        end
        check("rst_no_wb_after", 64'(pulses), 64'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = OP_MUL;
        bus.dest_addr = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("por_busy", 64'(bus.busy), 64'd0);
        check("por_done", 64'(bus.done), 64'd0);
        check("por_sw", 64'(bus.should_write), 64'd0);
        check("por_addr", 64'(bus.write_addr), 64'd0);
        check("por_data", bus.write_data, 64'd0);
        check("por_ovf", 64'(bus.overflow), 64'd0);
        check("por_dz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_2p5_m4", OP_MUL, 5'd3, 64'h0002_8000_0000_0000, 64'hFFFC_0000_0000_0000,
               66, 64'hFFF6_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        run_op("div_1_3", OP_DIV, 5'd7, 64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000,
               114, 64'h0000_5555_5555_5555, 1'b0, 1'b0, 1'b0);
        run_op("mul_sat_pos", OP_MUL, 5'd4, 64'h00C8_0000_0000_0000, 64'h00C8_0000_0000_0000,
               66, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("mul_sat_neg", OP_MUL, 5'd5, 64'hFF38_0000_0000_0000, 64'h00C8_0000_0000_0000,
               66, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        run_op("div_m1_0", OP_DIV, 5'd6, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_0000,
               2, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op("div_0_0", OP_DIV, 5'd8, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
               2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("mul_dest0", OP_MUL, 5'd0, 64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000,
               66, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        run_op("mul_min_half", OP_MUL, 5'd10, 64'h8000_0000_0000_0000, 64'h0000_8000_0000_0000,
               66, 64'hC000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        run_op("div_m7p5_2p5", OP_DIV, 5'd31, 64'hFFF8_8000_0000_0000, 64'h0002_8000_0000_0000,
               114, 64'hFFFD_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        run_op("mul_busy_start", OP_MUL, 5'd12, 64'h0002_8000_0000_0000, 64'hFFFC_0000_0000_0000,
               66, 64'hFFF6_0000_0000_0000, 1'b0, 1'b0, 1'b1);

        reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
